// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame scheduler: FSM states,
// byte-writer phases and the panel command opcodes.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CMD,
        ST_PIX,
        ST_DONE
    } state_t;

    // PH_LOW is the WR=0 half of a byte write, PH_HIGH the WR=1 half.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_LOW,
        PH_HIGH
    } phase_t;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [3:0] HDR_LEN = 4'd11;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/lcd_byte_writer.sv
// Two-cycle 8080 write generator: a load drives data/dc with WR low for one
// cycle, then WR high for one cycle, during which the next byte may be loaded.
module lcd_byte_writer
    import lcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_load,
    input  logic       i_clr,
    input  logic [7:0] i_data,
    input  logic       i_dc,
    output logic [7:0] o_data,
    output logic       o_dc,
    output logic       o_wr,
    output logic       o_busy,
    output logic       o_last
);

    phase_t     r_phase;
    logic [7:0] r_data;
    logic       r_dc;
    logic       r_wr;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_phase <= PH_IDLE;
            r_data  <= 8'h00;
            r_dc    <= DC_DATA;
            r_wr    <= 1'b1;
        end else if (i_load) begin
            r_phase <= PH_LOW;
            r_data  <= i_data;
            r_dc    <= i_dc;
            r_wr    <= 1'b0;
        end else begin
            r_wr <= 1'b1;
            // Clearing only returns the idle bus level; data is otherwise held.
            if (i_clr) begin
                r_data <= 8'h00;
                r_dc   <= DC_DATA;
            end
            case (r_phase)
                PH_LOW:  r_phase <= PH_HIGH;
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    assign o_data = r_data;
    assign o_dc   = r_dc;
    assign o_wr   = r_wr;
    assign o_busy = (r_phase == PH_LOW);
    assign o_last = (r_phase == PH_HIGH);

endmodule

// File: rtl/lcd_frame_sched.sv
// LCD write-bus owner: passes the init sequencer through until it finishes,
// then per frame request sends the window/RAMWR header and streams RGB565 pixels.
module lcd_frame_sched
    import lcd_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 96,
    parameter int PIX_W = 15
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic [7:0]  i_init_data,
    input  logic        i_init_wr,
    input  logic        i_init_dc,
    input  logic        i_init_fin,
    input  logic        i_frame_req,
    input  logic [15:0] i_pix_data,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_wr,
    output logic        o_lcd_dc,
    output logic        o_frame_busy,
    output logic        o_frame_done
);

    localparam logic [15:0]      COL_END  = 16'(H_RES - 1);
    localparam logic [15:0]      ROW_END  = 16'(V_RES - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(H_RES * V_RES - 1);
    localparam logic [PIX_W-1:0] CNT_ONE  = PIX_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_byte_idx;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [7:0]       r_pix_lo;
    logic             r_cur_hi;
    logic             r_last_pix;
    logic             r_busy;
    logic             r_done;

    logic [3:0] w_rom_idx;
    logic [7:0] w_rom_data;
    logic       w_rom_dc;
    logic       w_load;
    logic       w_clr;
    logic [7:0] w_ld_data;
    logic       w_ld_dc;
    logic       w_hdr_load;
    logic       w_lo_load;
    logic       w_ready;
    logic       w_accept;
    logic [7:0] w_wb_data;
    logic       w_wb_dc;
    logic       w_wb_wr;
    logic       w_wb_busy;
    logic       w_wb_last;

    lcd_byte_writer u_writer (
        .i_clk  (i_clk),
        .i_res  (i_res),
        .i_load (w_load),
        .i_clr  (w_clr),
        .i_data (w_ld_data),
        .i_dc   (w_ld_dc),
        .o_data (w_wb_data),
        .o_dc   (w_wb_dc),
        .o_wr   (w_wb_wr),
        .o_busy (w_wb_busy),
        .o_last (w_wb_last)
    );

    // The first header byte is issued from IDLE, before the index has advanced.
    assign w_rom_idx = (r_state == ST_IDLE) ? 4'd0 : r_byte_idx;

    always_comb begin
        w_rom_data = 8'h00;
        w_rom_dc   = DC_DATA;
        case (w_rom_idx)
            4'd0:  begin w_rom_data = CMD_CASET; w_rom_dc = DC_CMD; end
            4'd3:  w_rom_data = COL_END[15:8];
            4'd4:  w_rom_data = COL_END[7:0];
            4'd5:  begin w_rom_data = CMD_PASET; w_rom_dc = DC_CMD; end
            4'd8:  w_rom_data = ROW_END[15:8];
            4'd9:  w_rom_data = ROW_END[7:0];
            4'd10: begin w_rom_data = CMD_RAMWR; w_rom_dc = DC_CMD; end
            default: ;
        endcase
    end

    // Ready when the writer is empty or finishing a lo byte, so pixels chain at 4 cycles.
    assign w_ready  = (r_state == ST_PIX) && !r_last_pix && !w_wb_busy
                      && !(w_wb_last && r_cur_hi);
    assign w_accept = w_ready && i_pix_valid;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_clr        = 1'b0;
        w_ld_data    = w_rom_data;
        w_ld_dc      = w_rom_dc;
        w_hdr_load   = 1'b0;
        w_lo_load    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clr = 1'b1;
                if (i_init_fin) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_frame_req) begin
                    w_load       = 1'b1;
                    w_hdr_load   = 1'b1;
                    w_state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_wb_last) begin
                    if (r_byte_idx == HDR_LEN) begin
                        w_state_next = ST_PIX;
                    end else begin
                        w_load     = 1'b1;
                        w_hdr_load = 1'b1;
                    end
                end
            end
            ST_PIX: begin
                if (w_wb_last && r_cur_hi) begin
                    w_load    = 1'b1;
                    w_ld_data = r_pix_lo;
                    w_ld_dc   = DC_DATA;
                    w_lo_load = 1'b1;
                end else if (w_accept) begin
                    w_load    = 1'b1;
                    w_ld_data = i_pix_data[15:8];
                    w_ld_dc   = DC_DATA;
                end else if (w_wb_last && r_last_pix) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_clr        = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state    <= ST_INIT;
            r_byte_idx <= 4'd0;
            r_pix_cnt  <= '0;
            r_pix_lo   <= 8'h00;
            r_cur_hi   <= 1'b0;
            r_last_pix <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_CMD) || (w_state_next == ST_PIX);
            r_done  <= (w_state_next == ST_DONE);
            if (r_state == ST_IDLE && i_frame_req) begin
                r_byte_idx <= 4'd1;
                r_pix_cnt  <= '0;
                r_last_pix <= 1'b0;
            end else if (w_hdr_load) begin
                r_byte_idx <= r_byte_idx + 4'd1;
            end
            if (w_accept) begin
                r_pix_cnt  <= r_pix_cnt + CNT_ONE;
                r_pix_lo   <= i_pix_data[7:0];
                r_cur_hi   <= 1'b1;
                r_last_pix <= (r_pix_cnt == LAST_PIX);
            end else if (w_lo_load) begin
                r_cur_hi <= 1'b0;
            end
        end
    end

    assign o_lcd_data   = (r_state == ST_INIT) ? i_init_data : w_wb_data;
    assign o_lcd_wr     = (r_state == ST_INIT) ? i_init_wr   : w_wb_wr;
    assign o_lcd_dc     = (r_state == ST_INIT) ? i_init_dc   : w_wb_dc;
    assign o_pix_ready  = w_ready;
    assign o_frame_busy = r_busy;
    assign o_frame_done = r_done;

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Scoreboard bench for lcd_frame_sched: expected bus bytes are queued as the
// header/pixels are issued and popped on each rising WR edge of the panel bus.
module tb_lcd_frame_sched;

    localparam int H    = 320;
    localparam int V    = 3;
    localparam int PW   = 10;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        i_res;
    logic [7:0]  i_init_data;
    logic        i_init_wr;
    logic        i_init_dc;
    logic        i_init_fin;
    logic        i_frame_req;
    logic [15:0] i_pix_data;
    logic        i_pix_valid;
    logic        o_pix_ready;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_wr;
    logic        o_lcd_dc;
    logic        o_frame_busy;
    logic        o_frame_done;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic        prev_wr = 1'b1;
    logic [9:0]  sb_q[$];

    lcd_frame_sched #(.H_RES(H), .V_RES(V), .PIX_W(PW)) dut (
        .i_clk        (clk),
        .i_res        (i_res),
        .i_init_data  (i_init_data),
        .i_init_wr    (i_init_wr),
        .i_init_dc    (i_init_dc),
        .i_init_fin   (i_init_fin),
        .i_frame_req  (i_frame_req),
        .i_pix_data   (i_pix_data),
        .i_pix_valid  (i_pix_valid),
        .o_pix_ready  (o_pix_ready),
        .o_lcd_data   (o_lcd_data),
        .o_lcd_wr     (o_lcd_wr),
        .o_lcd_dc     (o_lcd_dc),
        .o_frame_busy (o_frame_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish, expected finish before 5ms");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_b(input logic dc, input logic [7:0] d);
        sb_q.push_back({1'b0, dc, d});
    endtask

    task automatic push_hdr();
        logic [15:0] ce;
        logic [15:0] re;
        ce = 16'(H - 1);
        re = 16'(V - 1);
        push_b(1'b0, 8'h2A); push_b(1'b1, 8'h00); push_b(1'b1, 8'h00);
        push_b(1'b1, ce[15:8]); push_b(1'b1, ce[7:0]);
        push_b(1'b0, 8'h2B); push_b(1'b1, 8'h00); push_b(1'b1, 8'h00);
        push_b(1'b1, re[15:8]); push_b(1'b1, re[7:0]);
        push_b(1'b0, 8'h2C);
    endtask

    // Advance one clock, sampling on the falling edge; pops the scoreboard on WR rise.
    task automatic cycle();
        logic [9:0] exp;
        @(negedge clk);
        cyc++;
        if (mon_en && prev_wr === 1'b0 && o_lcd_wr === 1'b1) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3ff;
            chk("bus_byte", {1'b0, o_lcd_dc, o_lcd_data}, exp);
        end
        prev_wr = o_lcd_wr;
    endtask

    // mode 0: constant F81F, 1: random with 7-cycle valid gaps, 2: random continuous.
    task automatic run_frame(input int mode, input bit keep_req, input int abort_at,
                             output int h_cyc, output int d_cyc);
        int          acc = 0;
        int          a_first = -1;
        int          a_last = 0;
        int          gap = 0;
        int          busy_low = 0;
        int          gap_low = 0;
        bit          hdr = 1'b0;
        bit          rdy = 1'b0;
        bit          done = 1'b0;
        bit          ab = 1'b0;
        logic [15:0] pix;
        h_cyc = 0;
        d_cyc = 0;
        pix = (mode == 0) ? 16'hF81F : 16'($urandom);
        for (int b = 0; b < 12 * NPIX + 200; b++) begin
            cycle();
            if (!hdr && o_lcd_wr === 1'b0) begin
                hdr = 1'b1;
                h_cyc = cyc;
                if (!keep_req) i_frame_req = 1'b0;
            end
            if (hdr && !rdy && o_pix_ready === 1'b1) begin
                rdy = 1'b1;
                chk("cmd_cycles", cyc - h_cyc, 22);
            end
            if (hdr && o_frame_busy !== 1'b1 && o_frame_done !== 1'b1) busy_low++;
            if (o_frame_done === 1'b1) begin
                done = 1'b1;
                d_cyc = cyc;
                break;
            end
            if (abort_at > 0 && hdr && cyc - h_cyc == abort_at) begin
                ab = 1'b1;
                break;
            end
            if (gap > 0) begin
                if (gap <= 3 && o_lcd_wr === 1'b0) gap_low++;
                i_pix_valid = 1'b0;
                gap--;
            end else begin
                i_pix_valid = 1'b1;
            end
            i_pix_data = pix;
            if (i_pix_valid && o_pix_ready === 1'b1) begin
                push_b(1'b1, pix[15:8]);
                push_b(1'b1, pix[7:0]);
                acc++;
                if (a_first < 0) a_first = cyc;
                a_last = cyc;
                if (mode == 1 && acc % 97 == 0) gap = 7;
                pix = (mode == 0) ? 16'hF81F : 16'($urandom);
            end
        end
        if (ab) return;
        i_pix_valid = 1'b0;
        if (!done) chk("frame_done_seen", 32'(done), 1);
        chk("pix_count", acc, NPIX);
        chk("busy_in_frame", busy_low, 0);
        chk("done_latency", d_cyc - a_last, 5);
        if (mode == 1) chk("gap_wr_low", gap_low, 0);
        else chk("pix_rate", d_cyc - a_first, 4 * (NPIX - 1) + 5);
        cycle();
        chk("done_pulse", o_frame_done, 0);
        chk("idle_busy", o_frame_busy, 0);
        chk("idle_bus", {o_lcd_dc, o_lcd_wr, o_lcd_data}, {1'b1, 1'b1, 8'h00});
        chk("sb_empty", sb_q.size(), 0);
        $display("frame mode=%0d pixels=%0d hdr_at=%0d done_at=%0d", mode, acc, h_cyc, d_cyc);
    endtask

    initial begin
        int h;
        int d;
        int fin_cyc;
        int prev_d;
        i_res = 1'b1;
        i_init_data = 8'hA5;
        i_init_wr = 1'b0;
        i_init_dc = 1'b1;
        i_init_fin = 1'b0;
        i_frame_req = 1'b0;
        i_pix_data = 16'h0000;
        i_pix_valid = 1'b0;
        repeat (3) cycle();
        chk("rst_busy", o_frame_busy, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_ready", o_pix_ready, 0);
        chk("rst_pass", {o_lcd_data, o_lcd_wr, o_lcd_dc}, {8'hA5, 1'b0, 1'b1});
        i_res = 1'b0;

        for (int k = 0; k < 16; k++) begin
            i_init_data = 8'($urandom);
            i_init_wr = 1'($urandom);
            i_init_dc = 1'($urandom);
            cycle();
            chk("init_pass", {o_lcd_data, o_lcd_wr, o_lcd_dc}, {i_init_data, i_init_wr, i_init_dc});
            chk("init_ready", o_pix_ready, 0);
            chk("init_busy", o_frame_busy, 0);
        end

        // Request raised in the same cycle as init completion.
        i_init_fin = 1'b1;
        i_frame_req = 1'b1;
        push_hdr();
        mon_en = 1'b1;
        prev_wr = 1'b1;
        fin_cyc = cyc;
        cycle();
        chk("idle_entry_busy", o_frame_busy, 0);
        chk("idle_entry_bus", {o_lcd_dc, o_lcd_wr, o_lcd_data}, {1'b1, 1'b1, 8'h00});
        run_frame(0, 1'b0, 0, h, d);
        chk("init_to_hdr", h - fin_cyc, 2);

        i_frame_req = 1'b1;
        push_hdr();
        run_frame(1, 1'b0, 0, h, d);

        // Held request: ignored while busy, re-armed right after DONE.
        i_frame_req = 1'b1;
        push_hdr();
        run_frame(2, 1'b1, 0, h, d);
        prev_d = d;
        push_hdr();
        run_frame(0, 1'b0, 40, h, d);
        chk("rearm_gap", h - prev_d, 2);

        // Reset in the middle of pixel streaming.
        i_res = 1'b1;
        i_pix_valid = 1'b0;
        i_init_data = 8'h3C;
        i_init_wr = 1'b0;
        i_init_dc = 1'b1;
        mon_en = 1'b0;
        sb_q.delete();
        cycle();
        chk("midrst_busy", o_frame_busy, 0);
        chk("midrst_ready", o_pix_ready, 0);
        chk("midrst_done", o_frame_done, 0);
        chk("midrst_pass", {o_lcd_data, o_lcd_wr, o_lcd_dc}, {8'h3C, 1'b0, 1'b1});
        i_res = 1'b0;
        cycle();
        chk("post_rst_idle", {o_lcd_dc, o_lcd_wr, o_lcd_data}, {1'b1, 1'b1, 8'h00});
        i_frame_req = 1'b1;
        push_hdr();
        mon_en = 1'b1;
        prev_wr = 1'b1;
        run_frame(2, 1'b0, 0, h, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
